sort_ctrl: RTL and testbench

- Sequencer that drives one pe_sort instance for a multi-beat sort job.
- Accepts a job command (beat count), pulls 256-bit beats from a valid/ready source, issues sorter_clr/sorter_en/last_sort, and forwards sorter results to a result stream.
- Sits between the PE-array data mover and pe_sort; signals job completion to the core controller.

---
 rtl/sort_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sort_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_ctrl.sv
// Job sequencer for one pe_sort instance: clear, feed N beats, forward results, report done.
// Optional WAIT-state watchdog enabled with `define SORT_CTRL_TIMEOUT_EN.
module sort_ctrl #(
  parameter int DATA_W      = 256,
  parameter int BEAT_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              job_start,
  input  logic [BEAT_W-1:0] job_beats,
  input  logic              job_abort,
  output logic              job_busy,
  output logic              job_done,
  output logic              job_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              sorter_clr,
  output logic              sorter_en,
  output logic              last_sort,
  output logic [DATA_W-1:0] sorter_in,
  input  logic [DATA_W-1:0] sorter_result,
  input  logic              sorter_valid,
  input  logic              last_sort_o,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_last
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_FEED, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              clr_q, clr_d, en_q, en_d, last_q, last_d;
  logic              rv_q, rv_d, rl_q, rl_d;
  logic [DATA_W-1:0] sin_q, sin_d, rd_q, rd_d;
  logic              fwd, accept, finish, abort_ev, timeout;

  assign finish = sorter_valid && last_sort_o;

`ifdef SORT_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;

  // Counter is zero in the first WAIT cycle, so the limit is hit in WAIT cycle TIMEOUT_CYC.
  assign wdog_d  = (state_q == S_WAIT) ? wdog_q + WD_W'(1) : '0;
  assign timeout = (state_q == S_WAIT) && (wdog_q == WD_W'(TIMEOUT_CYC - 1)) && !finish;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) wdog_q <= '0;
    else            wdog_q <= wdog_d;
  end
`else
  // Watchdog compiled out: never fires, WAIT may last forever.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  assign fwd      = (state_q == S_FEED) || (state_q == S_WAIT);
  assign accept   = (state_q == S_FEED) && in_valid && !job_abort;
  assign abort_ev = timeout || (job_abort && ((state_q == S_CLR) || (state_q == S_FEED) ||
                                              (state_q == S_WAIT)));

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    clr_d      = 1'b0;
    en_d       = 1'b0;
    last_d     = 1'b0;
    sin_d      = sin_q;
    rv_d       = fwd && sorter_valid;
    rl_d       = fwd && sorter_valid && last_sort_o;
    rd_d       = (fwd && sorter_valid) ? sorter_result : rd_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        // busy_q/done_q cover the job_done cycle, where a new start must be ignored.
        if (job_start && !busy_q && !done_q) begin
          if (job_beats != '0) begin
            beat_cnt_d = job_beats;
            busy_d     = 1'b1;
            clr_d      = 1'b1;
            state_d    = S_CLR;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      S_CLR:  state_d = S_FEED;
      S_FEED: begin
        if (accept) begin
          en_d       = 1'b1;
          sin_d      = in_data;
          beat_cnt_d = beat_cnt_q - BEAT_W'(1);
          if (beat_cnt_q == BEAT_W'(1)) begin
            last_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: if (finish) state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_ev) begin
      state_d    = S_IDLE;
      beat_cnt_d = '0;
      clr_d      = 1'b1;
      en_d       = 1'b0;
      last_d     = 1'b0;
      done_d     = 1'b1;
      err_d      = 1'b1;
      sin_d      = sin_q;
      rv_d       = 1'b0;
      rl_d       = 1'b0;
      rd_d       = rd_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      clr_q      <= 1'b0;
      en_q       <= 1'b0;
      last_q     <= 1'b0;
      sin_q      <= '0;
      rv_q       <= 1'b0;
      rl_q       <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      clr_q      <= clr_d;
      en_q       <= en_d;
      last_q     <= last_d;
      sin_q      <= sin_d;
      rv_q       <= rv_d;
      rl_q       <= rl_d;
      rd_q       <= rd_d;
    end
  end

  assign in_ready   = (state_q == S_FEED);
  assign job_busy   = busy_q;
  assign job_done   = done_q;
  assign job_err    = err_q;
  assign sorter_clr = clr_q;
  assign sorter_en  = en_q;
  assign last_sort  = last_q;
  assign sorter_in  = sin_q;
  assign res_valid  = rv_q;
  assign res_data   = rd_q;
  assign res_last   = rl_q;

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl with a small pe_sort stand-in (sorts the bytes of each beat).
module tb_sort_ctrl;
  localparam int DW = 256;
  localparam int BW = 8;
  localparam int TO = 16;

  logic          sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic          job_start = 1'b0, job_abort = 1'b0;
  logic [BW-1:0] job_beats = '0;
  logic          job_busy, job_done, job_err;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          sorter_clr, sorter_en, last_sort;
  logic [DW-1:0] sorter_in, sorter_result;
  logic          sorter_valid, last_sort_o;
  logic          res_valid, res_last;
  logic [DW-1:0] res_data;

  sort_ctrl #(.DATA_W(DW), .BEAT_W(BW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .job_start(job_start), .job_beats(job_beats), .job_abort(job_abort),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sorter_clr(sorter_clr), .sorter_en(sorter_en), .last_sort(last_sort),
    .sorter_in(sorter_in), .sorter_result(sorter_result),
    .sorter_valid(sorter_valid), .last_sort_o(last_sort_o),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] sort_bytes(input logic [DW-1:0] x);
    logic [7:0] b[32];
    logic [7:0] t;
    logic [DW-1:0] r;
    for (int i = 0; i < 32; i++) b[i] = x[i*8 +: 8];
    for (int i = 0; i < 31; i++)
      for (int j = 0; j < 31 - i; j++)
        if (b[j] > b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = b[i];
    return r;
  endfunction

  // pe_sort stand-in: sorted beat appears two cycles after sorter_en, flushed by sorter_clr.
  bit            stub_mute = 0, stub_nolast = 0;
  logic          s1_v, s2_v, s1_l, s2_l;
  logic [DW-1:0] s1_d, s2_d;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n || sorter_clr) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_l <= 1'b0; s2_l <= 1'b0; s1_d <= '0; s2_d <= '0;
    end else begin
      s1_v <= sorter_en && !stub_mute;
      s1_l <= sorter_en && last_sort && !stub_nolast;
      s1_d <= sort_bytes(sorter_in);
      s2_v <= s1_v; s2_l <= s1_l; s2_d <= s1_d;
    end
  end
  assign sorter_valid  = s2_v;
  assign last_sort_o   = s2_l;
  assign sorter_result = s2_d;

  typedef struct { logic [DW-1:0] d; logic l; } ent_t;
  ent_t          exp_en[$], exp_res[$];
  bit            exp_clr[$];
  logic          exp_done[$];
  logic [DW-1:0] bq[$];
  int            t_start, t_clr, t_en, t_enlast, t_rlast, t_done;
  bit            pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // Monitor: every DUT event pops its scoreboard queue.
  always @(negedge sys_clk) begin
    ent_t e;
    if (sys_rst_n) begin
      if (sorter_en) begin
        t_en = cyc;
        if (last_sort) t_enlast = cyc;
        if (exp_en.size() == 0) chk("unexpected_sorter_en", 1, 0);
        else begin
          e = exp_en.pop_front();
          chk("sorter_in", sorter_in, e.d);
          chk("last_sort", last_sort, e.l);
        end
      end else if (last_sort) chk("last_sort_without_en", last_sort, 0);
      if (sorter_clr) begin
        t_clr = cyc;
        chk("clr_with_en", sorter_en, 0);
        if (exp_clr.size() == 0) chk("unexpected_sorter_clr", 1, 0);
        else void'(exp_clr.pop_front());
      end
      if (res_valid) begin
        if (res_last) t_rlast = cyc;
        if (exp_res.size() == 0) chk("unexpected_res_valid", 1, 0);
        else begin
          e = exp_res.pop_front();
          chk("res_data", res_data, e.d);
          chk("res_last", res_last, e.l);
        end
      end
      if (job_done) begin
        if (exp_done.size() == 0) chk("unexpected_job_done", 1, 0);
        else chk("job_err", job_err, exp_done.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic gen(input int n);
    bq.delete();
    for (int i = 0; i < n; i++)
      bq.push_back({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic push_exp(input int k, input int n);
    ent_t e;
    for (int i = 0; i < k; i++) begin
      e.d = bq[i]; e.l = (i == n - 1);
      exp_en.push_back(e);
      if (!stub_mute) begin
        e.d = sort_bytes(bq[i]); e.l = (i == n - 1) && !stub_nolast;
        exp_res.push_back(e);
      end
    end
  endtask

  task automatic start_job(input int n);
    job_beats = BW'(n); job_start = 1'b1; t_start = cyc;
    step();
    job_start = 1'b0;
  endtask

  // mode 0: always valid, 1: fixed 1,0,1,1,0,1 pattern, 2: random valid
  task automatic feed(input int k, input int mode);
    int idx = 0, p = 0;
    bit acc;
    for (int g = 0; g < 300 && idx < k; g++) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = pat[p % 6];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? bq[idx] : {8{$urandom}};
      @(negedge sys_clk);
      acc = in_valid && in_ready;
      if (in_ready) p++;
      step();
      if (acc) idx++;
    end
    chk("feed_complete", idx, k);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge sys_clk);
      if (job_done) begin seen = 1; t_done = cyc; end
      step();
      if (seen) break;
    end
    chk("job_done_seen", seen, 1);
  endtask

  task automatic drained();
    chk("exp_en_drained", exp_en.size(), 0);
    chk("exp_res_drained", exp_res.size(), 0);
    chk("exp_clr_drained", exp_clr.size(), 0);
    chk("exp_done_drained", exp_done.size(), 0);
  endtask

  task automatic run_job(input int n, input int mode);
    exp_clr.push_back(1'b1);
    push_exp(n, n);
    exp_done.push_back(1'b0);
    start_job(n);
    feed(n, mode);
    wait_done(100);
    drained();
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    int n;
    // Reset with in_valid held high
    in_valid = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("rst_ctrl_outputs", {job_busy, job_done, job_err, in_ready, sorter_clr, sorter_en,
                               last_sort, res_valid, res_last}, 0);
      chk("rst_sorter_in", sorter_in, 0);
      chk("rst_res_data", res_data, 0);
      step();
    end
    in_valid = 1'b0;

    // Single beat, bytes descending so the sort is visible
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(31 - i);
    bq.delete(); bq.push_back(d);
    run_job(1, 0);
    chk("lat_clr", t_clr - t_start, 1);
    chk("lat_en", t_en - t_start, 3);
    chk("lat_done_after_res", t_done - t_rlast, 1);

    // Four beats, in_valid 1,0,1,1,0,1
    gen(4);
    exp_clr.push_back(1'b1); push_exp(4, 4); exp_done.push_back(1'b0);
    start_job(4);
    feed(4, 1);
    in_valid = 1'b1; in_data = {8{$urandom}};
    @(negedge sys_clk);
    chk("no_ready_after_last", in_ready, 0);
    step();
    in_valid = 1'b0;
    wait_done(100);
    drained();

    // Zero-beat job, then a start in its job_done cycle
    exp_done.push_back(1'b1);
    start_job(0);
    job_start = 1'b1; job_beats = 8'd1;
    @(negedge sys_clk);
    chk("zero_job_done", job_done, 1);
    chk("zero_busy", job_busy, 0);
    step();
    job_start = 1'b0;
    @(negedge sys_clk);
    chk("start_in_done_busy", job_busy, 0);
    chk("start_in_done_clr", sorter_clr, 0);
    step();
    drained();

    // Abort in FEED after 2 of 5 beats, then a clean 1-beat job
    gen(5);
    stub_mute = 1;
    exp_clr.push_back(1'b1); exp_clr.push_back(1'b1);
    push_exp(2, 5); exp_done.push_back(1'b1);
    start_job(5);
    feed(2, 0);
    job_abort = 1'b1; in_valid = 1'b1; in_data = {8{$urandom}};
    step();
    job_abort = 1'b0; in_valid = 1'b0;
    @(negedge sys_clk);
    chk("abort_ready_low", in_ready, 0);
    chk("abort_done", job_done, 1);
    chk("abort_busy_in_done", job_busy, 1);
    step();
    @(negedge sys_clk);
    chk("abort_idle_busy", job_busy, 0);
    step();
    stub_mute = 0;
    drained();
    gen(1);
    run_job(1, 0);

    // Random jobs
    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 6);
      gen(n);
      run_job(n, 2);
    end

    // Reset mid-job: everything clears, no job_done afterwards
    gen(3);
    exp_clr.push_back(1'b1);
    start_job(3);
    step();
    sys_rst_n = 1'b0; #1;
    chk("midrst_ctrl_outputs", {job_busy, job_done, in_ready, sorter_clr, sorter_en}, 0);
    step();
    sys_rst_n = 1'b1;
    exp_en.delete(); exp_res.delete(); exp_clr.delete(); exp_done.delete();
    repeat (4) step();
    chk("midrst_busy", job_busy, 0);
    drained();

    // Sorter never reports last_sort_o
    stub_nolast = 1;
    gen(2);
    exp_clr.push_back(1'b1); exp_clr.push_back(1'b1);
    push_exp(2, 2); exp_done.push_back(1'b1);
    start_job(2);
    feed(2, 0);
`ifdef SORT_CTRL_TIMEOUT_EN
    wait_done(60);
    chk("timeout_done_lat", t_done - t_enlast, TO);
    chk("timeout_clr_lat", t_clr - t_enlast, TO);
`else
    repeat (110) step();
    @(negedge sys_clk);
    chk("no_timeout_busy", job_busy, 1);
    step();
    job_abort = 1'b1;
    step();
    job_abort = 1'b0;
    wait_done(5);
`endif
    stub_nolast = 0;
    step();
    drained();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
